// File: rtl/shift_register_pkg.sv
// Shared types and constants for the rotating shift register.
// The next-state select decoding lives here so every stage agrees on it.
package shift_register_pkg;

  localparam int   SR_WIDTH_DEFAULT = 8;
  localparam logic SR_RESET_VAL     = '0;

  typedef enum logic [1:0] {
    SR_LOAD = 2'd0,
    SR_ROTL = 2'd1,
    SR_ROTR = 2'd2
  } sr_op_t;

  // dir only matters while rotating; a load ignores it.
  function automatic sr_op_t sr_decode_op(input logic shift, input logic dir);
    if (!shift) begin
      return SR_LOAD;
    end
    return dir ? SR_ROTR : SR_ROTL;
  endfunction

endpackage : shift_register_pkg

// File: rtl/shift_register_stage.sv
// One bit of the rotating register: async active-low clear flop behind a
// 3:1 mux of seed bit, lower-index neighbour and higher-index neighbour.
module shift_register_stage
  import shift_register_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  sr_op_t op,
  input  logic   d0_bit,
  input  logic   lsb_side,
  input  logic   msb_side,
  output logic   q
);

  logic q_next;

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    q_next = q;
    case (op)
      SR_LOAD: q_next = d0_bit;
      SR_ROTL: q_next = lsb_side;
      SR_ROTR: q_next = msb_side;
      default: q_next = q;
    endcase
  end

  // NOTE: non-blocking assignment keeps every stage sampling pre-edge neighbour values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SR_RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule : shift_register_stage

// File: rtl/shift_register.sv
// Parallel-load circular shift register built from WIDTH one-bit stages.
// Optional macro SHIFTREG_DIR_EN adds a dir input selecting right rotation.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic             shift,
`ifdef SHIFTREG_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 2) begin : g_width_check
    $error("shift_register: WIDTH must be at least 2");
  end

  sr_op_t           op;
  logic [WIDTH-1:0] q_bits;

`ifdef SHIFTREG_DIR_EN
  assign op = sr_decode_op(shift, dir);
`else
  assign op = sr_decode_op(shift, 1'b0);
`endif

  // Neighbour indices wrap so the MSB feeds bit 0 on a left rotate and
  // bit 0 feeds the MSB on a right rotate.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    localparam int LO = (i + WIDTH - 1) % WIDTH;
    localparam int HI = (i + 1) % WIDTH;

    shift_register_stage u_stage (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .d0_bit   (D0[i]),
      .lsb_side (q_bits[LO]),
      .msb_side (q_bits[HI]),
      .q        (q_bits[i])
    );
  end

  assign Q = q_bits;

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register (WIDTH=8); exercises the dir port
// when SHIFTREG_DIR_EN is defined.
module tb_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] D0;
  logic         shift;
  logic         dir;
  logic [W-1:0] Q;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  shift_register #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .D0    (D0),
    .shift (shift),
`ifdef SHIFTREG_DIR_EN
    .dir   (dir),
`endif
    .Q     (Q)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, want);
    end
  endtask

  // Drive one cycle: predict from the register behaviour, push, clock, pop and compare.
  task automatic step(input logic sh, input logic [W-1:0] d, input logic dr, input string tag);
    logic [W-1:0] want;
    shift = sh;
    D0    = d;
    dir   = dr;
    if (!rst) begin
      model_q = '0;
    end else if (!sh) begin
      model_q = d;
    end else begin
`ifdef SHIFTREG_DIR_EN
      if (dr) model_q = {model_q[0], model_q[W-1:1]};
      else    model_q = {model_q[W-2:0], model_q[W-1]};
`else
      model_q = {model_q[W-2:0], model_q[W-1]};
`endif
    end
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, Q, ~Q);
    end else begin
      want = exp_q.pop_front();
      check(tag, Q, want);
    end
  endtask

  // Drop rst halfway through a cycle and confirm Q clears before any edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    model_q = '0;
    #1;
    check(tag, Q, 8'h00);
  endtask

  logic [W-1:0] rot_tbl [8];
  logic [W-1:0] wrap_tbl [3];

  initial begin
    rot_tbl  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    wrap_tbl = '{8'h03, 8'h06, 8'h0C};
    rst = 1'b0; D0 = 8'h01; shift = 1'b0; dir = 1'b0; model_q = '0;
    #1;
    check("reset_initial", Q, 8'h00);
    @(posedge clk); #1;

    // Give Q something nonzero so the async clear is observable.
    rst = 1'b1;
    step(1'b0, 8'hA5, 1'b0, "preload_a5");
    D0 = 8'h01; shift = 1'b0;
    async_reset("async_reset_mid_cycle");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h01, 1'b0, "reset_hold");
      check("reset_hold_const", Q, 8'h00);
    end

    rst = 1'b1;
    step(1'b0, 8'h01, 1'b0, "load_01");
    check("load_01_const", Q, 8'h01);
    step(1'b0, 8'hA5, 1'b0, "load_a5");
    check("load_a5_const", Q, 8'hA5);

    step(1'b0, 8'h01, 1'b0, "load_01_again");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h00, 1'b0, "rotl");
      check("rotl_const", Q, rot_tbl[i]);
    end

    step(1'b0, 8'h81, 1'b0, "load_81");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00, 1'b0, "wrap");
      check("wrap_const", Q, wrap_tbl[i]);
    end

    step(1'b0, 8'hFF, 1'b0, "load_ff");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00, 1'b0, "ones_rot");
      check("ones_const", Q, 8'hFF);
    end

    step(1'b0, 8'h01, 1'b0, "load_01_mid");
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0, "rot_to_10");
    check("at_10", Q, 8'h10);
    shift = 1'b1;
    async_reset("reset_mid_rotation");
    step(1'b1, 8'h00, 1'b0, "rot_in_reset");
    rst = 1'b1;
    step(1'b1, 8'hFF, 1'b0, "rot_zero_1");
    check("rot_zero_const", Q, 8'h00);
    step(1'b1, 8'hFF, 1'b0, "rot_zero_2");

`ifdef SHIFTREG_DIR_EN
    step(1'b0, 8'h01, 1'b1, "dir_load_01");
    step(1'b1, 8'h00, 1'b1, "rotr_1");
    check("rotr_1_const", Q, 8'h80);
    step(1'b1, 8'h00, 1'b1, "rotr_2");
    check("rotr_2_const", Q, 8'h40);
    step(1'b1, 8'h00, 1'b0, "rotl_back");
    check("rotl_back_const", Q, 8'h80);
`endif

    // Random mix of loads and rotations against the scoreboard model.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom), "random");
    end

    check("sb_drained", W'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_register
